// File: rtl/mul_hilo_ctrl.sv
// Issue/write-back controller for the 32x32 multiplier: owns HI/LO and the MFHI/MFLO busy interlock.
// Optional build macro MUL_HILO_BYPASS_EN forwards the final product to hi/lo one cycle early.
module mul_hilo_ctrl #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic        mul_clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    output logic        mul_signed,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic       IDLE = 1'b0;
    localparam logic       MUL  = 1'b1;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    localparam logic [2:0] LAT = 3'(MUL_LATENCY);

    logic        state;
    logic [2:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        accept;
    logic        is_mul_op;
    logic        write_back;

    assign req_ready  = (state == IDLE) & ~flush;
    assign accept     = req_valid & req_ready;
    assign is_mul_op  = (req_op == OP_MULT) | (req_op == OP_MULTU);
    assign write_back = (state == MUL) & (cnt == 3'd0) & ~flush;

    // Flush only ever leaves MUL; in IDLE it merely blocks acceptance through req_ready.
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul_op) begin
                        state <= MUL;
                        cnt   <= LAT;
                    end
                end
                MUL: begin
                    if (flush || cnt == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands stay put after a flush; the next accept overwrites them anyway.
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            mul_x      <= 32'd0;
            mul_y      <= 32'd0;
            mul_signed <= 1'b0;
        end else if (accept && is_mul_op) begin
            mul_x      <= req_rs;
            mul_y      <= req_rt;
            mul_signed <= (req_op == OP_MULT);
        end
    end

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (write_back) begin
            hi_q <= mul_result[63:32];
            lo_q <= mul_result[31:0];
        end else if (accept && req_op == OP_MTHI) begin
            hi_q <= req_rs;
        end else if (accept && req_op == OP_MTLO) begin
            lo_q <= req_rs;
        end
    end

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            done <= 1'b0;
        end else begin
            done <= write_back;
        end
    end

`ifdef MUL_HILO_BYPASS_EN
    assign hi   = write_back ? mul_result[63:32] : hi_q;
    assign lo   = write_back ? mul_result[31:0]  : lo_q;
    assign busy = (state == MUL) & ~write_back;
`else
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state == MUL);
`endif

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a behavioural multiplier and a HI/LO scoreboard.
// Expectations follow MUL_HILO_BYPASS_EN when it is defined for the build.
module tb_mul_hilo_ctrl;

    localparam int LAT = 1;

    logic        mul_clk;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        mul_signed;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [63:0] mul_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [63:0] pipe [LAT];

`ifdef MUL_HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    mul_hilo_ctrl #(.MUL_LATENCY(LAT)) dut (
        .mul_clk   (mul_clk),
        .resetn    (resetn),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .mul_signed(mul_signed),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_result(mul_result),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    initial mul_clk = 1'b0;
    always #5 mul_clk = ~mul_clk;

    function automatic logic [63:0] product(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'd0, x};
        ye = s ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    // Behavioural multiplier: LAT register stages from operands to result.
    always_ff @(posedge mul_clk) begin
        pipe[0] <= product(mul_x, mul_y, mul_signed);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_result = pipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mul_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        req_valid = 1'b1;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
    endtask

    // Scoreboard: every done pulse must match the oldest pending product.
    always @(negedge mul_clk) begin
        if (resetn && done) begin
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("sb_hilo", {hi, lo}, sb.pop_front());
        end
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0;
        req_op = 2'b00; req_rs = 32'd0; req_rt = 32'd0;
        tick(); tick();
        resetn = 1'b1;
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_mulside", {31'd0, mul_signed, mul_x}, 64'd0);
        check("rst_muly", 64'(mul_y), 64'd0);

        // MULT -1 * 2
        apply_stimulus(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        req_valid = 1'b0;
        check("mult_signed", 64'(mul_signed), 64'd1);
        check("mult_busy_e0", 64'(busy), 64'd1);
        check("mult_ready_e0", 64'(req_ready), 64'd0);
        check("mult_done_e0", 64'(done), 64'd0);
        tick();
        check("mult_ready_e1", 64'(req_ready), 64'd0);
        check("mult_busy_e1", 64'(busy), BYP ? 64'd0 : 64'd1);
        check("mult_hi_e1", 64'(hi), BYP ? 64'hFFFF_FFFF : 64'd0);
        tick();
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mult_done_e2", 64'(done), 64'd1);
        check("mult_ready_e2", 64'(req_ready), 64'd1);
        tick();
        check("mult_done_e3", 64'(done), 64'd0);

        // MULTU 0xFFFFFFFF * 2
        apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        sb.push_back(64'h0000_0001_FFFF_FFFE);
        tick();
        req_valid = 1'b0;
        check("multu_signed", 64'(mul_signed), 64'd0);
        tick(); tick();
        check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        check("multu_done", 64'(done), 64'd1);

        // MTHI then MTLO back-to-back
        apply_stimulus(2'b10, 32'h1234_5678, 32'd0);
        check("mthi_ready", 64'(req_ready), 64'd1);
        tick();
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        apply_stimulus(2'b11, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        check("mtlo_done", 64'(done), 64'd0);

        // MULT 7*6 flushed on the write-back cycle
        apply_stimulus(2'b00, 32'd7, 32'd6);
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(req_ready), 64'd0);
        check("flush_hi_nobyp", 64'(hi), 64'h1234_5678);
        tick();
        flush = 1'b0;
        check("flush_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        tick();
        check("flush_done2", 64'(done), 64'd0);

        // Reset in the middle of a MULT
        apply_stimulus(2'b00, 32'd3, 32'd4);
        tick();
        req_valid = 1'b0;
        check("rstmid_busy_pre", 64'(busy), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rstmid_hilo", {hi, lo}, 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_ops", {mul_x, mul_y}, 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        check("rstmid_done2", 64'(done), 64'd0);
        check("rstmid_ready", 64'(req_ready), 64'd1);

        // MULTU 3*5: bypass visibility one cycle before write-back
        apply_stimulus(2'b01, 32'd3, 32'd5);
        sb.push_back(64'h0000_0000_0000_000F);
        tick();
        req_valid = 1'b0;
        tick();
        check("byp_lo", 64'(lo), BYP ? 64'h0000_000F : 64'd0);
        check("byp_busy", 64'(busy), BYP ? 64'd0 : 64'd1);
        tick();
        check("byp_lo_wb", 64'(lo), 64'h0000_000F);
        check("byp_done", 64'(done), 64'd1);
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
